// File: rtl/multi_fill_drain_ctrl.sv
`timescale 1ns/1ps
// Multi-channel fill/drain level sequencer: each enabled channel ramps between runtime HI/LO thresholds.
// Optional build macro MULTI_FILL_DRAIN_DWELL_EN adds DWELL-cycle holds at HI and LO.
module multi_fill_drain_ctrl #(
    parameter int NCH   = 4,
    parameter int CBITS = 13,
    parameter int MAXV  = 7500,
    parameter int STEP  = 1,
    parameter int DWELL = 4,
    localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   en,
    input  logic             cfg_load,
    input  logic [CBITS-1:0] cfg_hi,
    input  logic [CBITS-1:0] cfg_lo,
    output logic             cfg_err,
    output logic [NCH-1:0]   full,
    output logic [NCH-1:0]   empty,
    output logic [NCH-1:0]   dir,
    output logic             any_full,
    input  logic [SELW-1:0]  rd_sel,
    output logic [CBITS-1:0] rd_level
);

    if (NCH < 1 || NCH > 16 || STEP < 1 || STEP > MAXV || MAXV >= (1 << CBITS) || DWELL < 1) begin : g_bad_params
        $error("multi_fill_drain_ctrl: illegal parameter combination");
    end

    localparam logic [CBITS:0]   STEP_W = (CBITS+1)'(STEP);
    localparam logic [CBITS:0]   MAXV_W = (CBITS+1)'(MAXV);
    localparam logic [CBITS-1:0] STEP_C = CBITS'(STEP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_DRAIN
`ifdef MULTI_FILL_DRAIN_DWELL_EN
        , S_DWELL_HI,
        S_DWELL_LO
`endif
    } state_t;

`ifdef MULTI_FILL_DRAIN_DWELL_EN
    localparam int DCW = $clog2(DWELL + 1);
    logic [DCW-1:0] cnt_q [NCH];
    logic [DCW-1:0] cnt_d [NCH];
`endif

    state_t           state_q [NCH];
    state_t           state_d [NCH];
    logic [CBITS-1:0] level_q [NCH];
    logic [CBITS-1:0] level_d [NCH];
    logic [CBITS-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [NCH-1:0]   full_q, full_d, empty_q, empty_d, dir_q, dir_d;
    logic             any_full_q, any_full_d, cfg_err_q, cfg_err_d, cfg_ok;
    logic [CBITS-1:0] rd_level_q;

    // Threshold tests at CBITS+1 bits so level+STEP cannot wrap.
    function automatic logic hits_hi(input logic [CBITS-1:0] lvl, input logic [CBITS-1:0] hi);
        return ({1'b0, lvl} + STEP_W) >= {1'b0, hi};
    endfunction

    function automatic logic hits_lo(input logic [CBITS-1:0] lvl, input logic [CBITS-1:0] lo);
        return {1'b0, lvl} <= ({1'b0, lo} + STEP_W);
    endfunction

    always_comb begin
        cfg_ok    = cfg_load && (cfg_lo < cfg_hi) && ({1'b0, cfg_hi} <= MAXV_W);
        cfg_err_d = cfg_load && !cfg_ok;
        hi_d      = cfg_ok ? cfg_hi : hi_q;
        lo_d      = cfg_ok ? cfg_lo : lo_q;
        full_d    = '0;
        empty_d   = '0;
        dir_d     = '0;
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            level_d[i] = level_q[i];
`ifdef MULTI_FILL_DRAIN_DWELL_EN
            cnt_d[i] = en[i] ? cnt_q[i] : '0;
`endif
            if (cfg_ok) begin
                // The clamp takes the place of this cycle's step; states are kept.
                if (level_q[i] > cfg_hi) begin
                    level_d[i] = cfg_hi;
                end else if (level_q[i] < cfg_lo) begin
                    level_d[i] = cfg_lo;
                end
                if (!en[i]) begin
                    state_d[i] = S_IDLE;
                end
            end else if (!en[i]) begin
                state_d[i] = S_IDLE;
            end else begin
                case (state_q[i])
                    S_IDLE: begin
                        if (level_q[i] < hi_q) begin
                            state_d[i] = S_FILL;
                        end else begin
                            state_d[i] = S_DRAIN;
                        end
                    end
                    S_FILL: begin
                        if (hits_hi(level_q[i], hi_q)) begin
                            level_d[i] = hi_q;
`ifdef MULTI_FILL_DRAIN_DWELL_EN
                            state_d[i] = S_DWELL_HI;
                            cnt_d[i]   = '0;
`else
                            state_d[i] = S_DRAIN;
`endif
                        end else begin
                            level_d[i] = level_q[i] + STEP_C;
                        end
                    end
                    S_DRAIN: begin
                        if (hits_lo(level_q[i], lo_q)) begin
                            level_d[i] = lo_q;
`ifdef MULTI_FILL_DRAIN_DWELL_EN
                            state_d[i] = S_DWELL_LO;
                            cnt_d[i]   = '0;
`else
                            state_d[i] = S_FILL;
`endif
                        end else begin
                            level_d[i] = level_q[i] - STEP_C;
                        end
                    end
`ifdef MULTI_FILL_DRAIN_DWELL_EN
                    // Leaving a dwell performs the first step of the new ramp on the same edge.
                    S_DWELL_HI: begin
                        if (cnt_q[i] == DCW'(DWELL)) begin
                            cnt_d[i] = '0;
                            if (hits_lo(level_q[i], lo_q)) begin
                                level_d[i] = lo_q;
                                state_d[i] = S_DWELL_LO;
                            end else begin
                                level_d[i] = level_q[i] - STEP_C;
                                state_d[i] = S_DRAIN;
                            end
                        end else begin
                            cnt_d[i] = cnt_q[i] + DCW'(1);
                        end
                    end
                    S_DWELL_LO: begin
                        if (cnt_q[i] == DCW'(DWELL)) begin
                            cnt_d[i] = '0;
                            if (hits_hi(level_q[i], hi_q)) begin
                                level_d[i] = hi_q;
                                state_d[i] = S_DWELL_HI;
                            end else begin
                                level_d[i] = level_q[i] + STEP_C;
                                state_d[i] = S_FILL;
                            end
                        end else begin
                            cnt_d[i] = cnt_q[i] + DCW'(1);
                        end
                    end
`endif
                    default: state_d[i] = S_IDLE;
                endcase
            end
            full_d[i]  = (state_d[i] != S_IDLE) && (level_d[i] == hi_d);
            empty_d[i] = (state_d[i] != S_IDLE) && (level_d[i] == lo_d);
            dir_d[i]   = (state_d[i] == S_FILL);
        end
        any_full_d = |full_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q       <= CBITS'(MAXV);
            lo_q       <= '0;
            cfg_err_q  <= 1'b0;
            full_q     <= '0;
            empty_q    <= '0;
            dir_q      <= '0;
            any_full_q <= 1'b0;
            rd_level_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= S_IDLE;
                level_q[i] <= '0;
`ifdef MULTI_FILL_DRAIN_DWELL_EN
                cnt_q[i]   <= '0;
`endif
            end
        end else begin
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            cfg_err_q  <= cfg_err_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            dir_q      <= dir_d;
            any_full_q <= any_full_d;
            rd_level_q <= (32'(rd_sel) < NCH) ? level_q[rd_sel] : '0;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                level_q[i] <= level_d[i];
`ifdef MULTI_FILL_DRAIN_DWELL_EN
                cnt_q[i]   <= cnt_d[i];
`endif
            end
        end
    end

    assign cfg_err  = cfg_err_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign dir      = dir_q;
    assign any_full = any_full_q;
    assign rd_level = rd_level_q;

endmodule

// File: tb/tb_multi_fill_drain_ctrl.sv
`timescale 1ns/1ps
// Bench for multi_fill_drain_ctrl: directed scenarios plus random traffic against a level/direction model.
module tb_multi_fill_drain_ctrl;
    localparam int NCH   = 4;
    localparam int CBITS = 13;
    localparam int MAXV  = 7500;
    localparam int OW    = 2 + 3*NCH + CBITS;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NCH-1:0]   en = '0;
    logic             cfg_load = 1'b0;
    logic [CBITS-1:0] cfg_hi = '0, cfg_lo = '0;
    logic [1:0]       rd_sel = '0;

    logic             cfg_err, any_full, cfg_err3, any_full3;
    logic [NCH-1:0]   full, empty, dir, full3, empty3, dir3;
    logic [CBITS-1:0] rd_level, rd_level3;

    always #5 clk = ~clk;

    multi_fill_drain_ctrl #(.NCH(NCH), .CBITS(CBITS), .MAXV(MAXV), .STEP(1), .DWELL(4)) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_load(cfg_load), .cfg_hi(cfg_hi), .cfg_lo(cfg_lo),
        .cfg_err(cfg_err), .full(full), .empty(empty), .dir(dir), .any_full(any_full),
        .rd_sel(rd_sel), .rd_level(rd_level));

    multi_fill_drain_ctrl #(.NCH(NCH), .CBITS(CBITS), .MAXV(MAXV), .STEP(3), .DWELL(4)) dut3 (
        .clk(clk), .rst(rst), .en(en), .cfg_load(cfg_load), .cfg_hi(cfg_hi), .cfg_lo(cfg_lo),
        .cfg_err(cfg_err3), .full(full3), .empty(empty3), .dir(dir3), .any_full(any_full3),
        .rd_sel(rd_sel), .rd_level(rd_level3));

    // Reference model: a level and a direction (+1 up, -1 down, 0 idle) per channel.
    int               m_level [NCH];
    int               m_dir   [NCH];
    int               m_hi, m_lo;
    logic             e_err, e_any;
    logic [NCH-1:0]   e_full, e_empty, e_dir;
    logic [CBITS-1:0] e_rd;

    int vectors = 0;
    int miscompares = 0;

    task automatic model_step();
        bit acc;
        if (rst) begin
            m_hi  = MAXV;
            m_lo  = 0;
            e_err = 1'b0;
            e_rd  = '0;
            for (int i = 0; i < NCH; i++) begin
                m_level[i] = 0;
                m_dir[i]   = 0;
            end
        end else begin
            e_rd  = CBITS'(m_level[rd_sel]);
            acc   = cfg_load && (cfg_lo < cfg_hi) && (int'(cfg_hi) <= MAXV);
            e_err = cfg_load && !acc;
            for (int i = 0; i < NCH; i++) begin
                if (acc) begin
                    if (m_level[i] > int'(cfg_hi)) m_level[i] = int'(cfg_hi);
                    if (m_level[i] < int'(cfg_lo)) m_level[i] = int'(cfg_lo);
                    if (!en[i]) m_dir[i] = 0;
                end else if (!en[i]) begin
                    m_dir[i] = 0;
                end else if (m_dir[i] == 0) begin
                    m_dir[i] = (m_level[i] < m_hi) ? 1 : -1;
                end else begin
                    m_level[i] = m_level[i] + m_dir[i];
                    if (m_level[i] >= m_hi) begin
                        m_level[i] = m_hi;
                        m_dir[i]   = -1;
                    end else if (m_level[i] <= m_lo) begin
                        m_level[i] = m_lo;
                        m_dir[i]   = 1;
                    end
                end
            end
            if (acc) begin
                m_hi = int'(cfg_hi);
                m_lo = int'(cfg_lo);
            end
        end
        for (int i = 0; i < NCH; i++) begin
            e_full[i]  = (m_dir[i] != 0) && (m_level[i] == m_hi);
            e_empty[i] = (m_dir[i] != 0) && (m_level[i] == m_lo);
            e_dir[i]   = (m_dir[i] == 1);
        end
        e_any = |e_full;
    endtask

    function automatic logic [OW-1:0] obs();
        return {cfg_err, full, empty, dir, any_full, rd_level};
    endfunction

    function automatic logic [OW-1:0] exp_vec();
        return {e_err, e_full, e_empty, e_dir, e_any, e_rd};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1; en = '0; cfg_load = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = '1; cfg_load = 1'b1; cfg_hi = 13'd3; cfg_lo = 13'd1; rd_sel = 2'd1;
        tick();
        vectors++;
        if (obs() !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected 0", obs());
        end
        rst = 1'b0; en = '0; cfg_load = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (k == 1) en = '1;
            tick();
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset_release: got %h expected %h", obs(), exp_vec());
            end
        end
    endtask

    task automatic test_fill_full();
        int first;
        apply_reset();
        en = 4'b0001; rd_sel = 2'd3; first = 0;
        for (int n = 1; n <= 7505; n++) begin
            tick();
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("FAIL fill_ramp cyc %0d: got %h expected %h", n, obs(), exp_vec());
            end
            if (full[0] === 1'b1 && first == 0) first = n;
            if (n == 7502) begin
                vectors++;
                if (full[0] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL full_width: full[0]=%b expected 0", full[0]);
                end
            end
        end
        vectors++;
        if (first != 7501) begin
            miscompares++;
            $display("FAIL full_cycle: first full at %0d expected 7501", first);
        end
    endtask

    task automatic test_cfg_clamp();
        int prev, nr, r0, r1;
        apply_reset();
        en = 4'b0010; rd_sel = 2'd1;
        for (int n = 0; n < 200 && m_level[1] != 50; n++) begin
            tick();
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("FAIL clamp_ramp: got %h expected %h", obs(), exp_vec());
            end
        end
        cfg_load = 1'b1; cfg_hi = 13'd10; cfg_lo = 13'd2;
        tick();
        cfg_load = 1'b0;
        tick();
        vectors++;
        if (rd_level !== 13'd10) begin
            miscompares++;
            $display("FAIL clamp_level: got %0d expected 10", rd_level);
        end
        prev = 0; nr = 0; r0 = 0; r1 = 0;
        for (int n = 0; n < 60; n++) begin
            tick();
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("FAIL clamp_bounce: got %h expected %h", obs(), exp_vec());
            end
            if (empty[1] === 1'b1 && prev == 0) begin
                if (nr == 0) r0 = n;
                if (nr == 1) r1 = n;
                nr++;
            end
            prev = (empty[1] === 1'b1) ? 1 : 0;
        end
        vectors++;
        if (nr < 2 || r1 - r0 != 16) begin
            miscompares++;
            $display("FAIL clamp_period: got %0d rises gap %0d expected gap 16", nr, r1 - r0);
        end
    endtask

    task automatic test_cfg_reject();
        int first;
        apply_reset();
        cfg_load = 1'b1; cfg_hi = 13'd20; cfg_lo = 13'd4;
        tick();
        cfg_hi = 13'd5; cfg_lo = 13'd5;
        tick();
        vectors++;
        if (cfg_err !== 1'b1) begin
            miscompares++;
            $display("FAIL reject_equal: cfg_err=%b expected 1", cfg_err);
        end
        cfg_load = 1'b0;
        tick();
        vectors++;
        if (cfg_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reject_pulse: cfg_err=%b expected 0", cfg_err);
        end
        cfg_load = 1'b1; cfg_hi = 13'd8000; cfg_lo = 13'd0;
        tick();
        vectors++;
        if (obs() !== exp_vec() || cfg_err !== 1'b1) begin
            miscompares++;
            $display("FAIL reject_max: got %h expected %h", obs(), exp_vec());
        end
        cfg_load = 1'b0; en = 4'b0001; rd_sel = 2'd0; first = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("FAIL reject_run: got %h expected %h", obs(), exp_vec());
            end
            if (full[0] === 1'b1 && first == 0) first = n;
        end
        vectors++;
        if (first != 17) begin
            miscompares++;
            $display("FAIL reject_thresh: first full at %0d expected 17", first);
        end
    endtask

    task automatic test_en_drop();
        apply_reset();
        en = 4'b0100; rd_sel = 2'd2;
        for (int n = 0; n < 100 && m_level[2] != 37; n++) tick();
        en = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            tick();
            vectors++;
            if (dir[2] !== 1'b0 || rd_level !== 13'd37 || obs() !== exp_vec()) begin
                miscompares++;
                $display("FAIL en_hold k=%0d: dir=%b level=%0d expected dir 0 level 37", k, dir[2], rd_level);
            end
        end
        en = 4'b0100;
        tick();
        vectors++;
        if (dir[2] !== 1'b1 || obs() !== exp_vec()) begin
            miscompares++;
            $display("FAIL en_entry: got %h expected %h", obs(), exp_vec());
        end
        tick();
        tick();
        vectors++;
        if (rd_level !== 13'd38) begin
            miscompares++;
            $display("FAIL en_resume: level %0d expected 38", rd_level);
        end
    endtask

    task automatic test_step3();
        int seq [11];
        seq = '{0, 0, 3, 6, 9, 10, 7, 4, 1, 0, 3};
        apply_reset();
        cfg_load = 1'b1; cfg_hi = 13'd10; cfg_lo = 13'd0;
        tick();
        cfg_load = 1'b0; en = 4'b0001; rd_sel = 2'd0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            vectors++;
            if (full3[0] !== (seq[k] == 10) || empty3[0] !== (seq[k] == 0) || int'(rd_level3) != seq[k-1]) begin
                miscompares++;
                $display("FAIL step3 k=%0d: full=%b empty=%b prev_level=%0d expected level %0d prev %0d",
                         k, full3[0], empty3[0], rd_level3, seq[k], seq[k-1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        en = '1;
        for (int n = 0; n < 40; n++) begin
            cfg_load = (n == 20 || n == 21 || n == 22 || n == 23);
            cfg_hi = (n == 20) ? 13'd30 : (n == 21) ? 13'd12 : (n == 22) ? 13'd3 : 13'd15;
            cfg_lo = (n == 20) ? 13'd10 : (n == 21) ? 13'd8 : (n == 22) ? 13'd7 : 13'd11;
            rd_sel = 2'(n);
            tick();
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("FAIL back_to_back n=%0d: got %h expected %h", n, obs(), exp_vec());
            end
        end
        cfg_load = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        en = '1;
        for (int n = 0; n < 25; n++) tick();
        rst = 1'b1; cfg_load = 1'b1; cfg_hi = 13'd30; cfg_lo = 13'd3;
        tick();
        vectors++;
        if (obs() !== '0 || {full3, empty3, dir3, any_full3, cfg_err3} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: got %h expected 0", obs());
        end
        rst = 1'b0; cfg_load = 1'b0;
        tick();
        vectors++;
        if (obs() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_mid_release: got %h expected %h", obs(), exp_vec());
        end
    endtask

    task automatic test_random();
        int k;
        apply_reset();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) begin
                k = int'($urandom_range(0, NCH-1));
                en[k] = ~en[k];
            end
            cfg_load = ($urandom_range(0, 29) == 0);
            case ($urandom_range(0, 3))
                0, 1: begin
                    cfg_hi = CBITS'($urandom_range(0, 40));
                    cfg_lo = CBITS'($urandom_range(0, 40));
                end
                2: begin
                    cfg_hi = CBITS'($urandom_range(7400, 8191));
                    cfg_lo = CBITS'($urandom_range(0, 50));
                end
                default: begin
                    cfg_hi = CBITS'($urandom_range(0, 20));
                    cfg_lo = cfg_hi;
                end
            endcase
            rd_sel = 2'($urandom_range(0, 3));
            tick();
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random n=%0d: got %h expected %h", n, obs(), exp_vec());
            end
        end
        rst = 1'b0; cfg_load = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill_full();
        test_cfg_clamp();
        test_cfg_reject();
        test_en_drop();
        test_step3();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
